// File: rtl/cache_pkg.sv
// Shared types and size helpers for the cache line refill engine.
package cache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Number of RAM beats that make up one cache line.
  function automatic int beats_f(input int line_w, input int ram_w);
    return line_w / ram_w;
  endfunction

  // Requester index width, never narrower than one bit.
  function automatic int idw_f(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Byte-offset width inside one RAM beat.
  function automatic int boff_w_f(input int ram_w);
    return $clog2(ram_w / 8);
  endfunction

  // Byte-offset width inside one cache line.
  function automatic int loff_w_f(input int line_w);
    return $clog2(line_w / 8);
  endfunction

  // Beat index width, never narrower than one bit.
  function automatic int bidx_w_f(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/cache_rr_arbiter.sv
// Round-robin arbiter: the pointer names the requester with top priority
// and moves just past the winner whenever a grant is taken.
module cache_rr_arbiter
  import cache_pkg::*;
#(
  parameter  int N   = 2,
  localparam int IDW = idw_f(N)
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic [N-1:0]   req,
  input  logic           advance,
  output logic           grant_valid,
  output logic [IDW-1:0] grant_idx
);

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] idx;

  // Scan from the farthest candidate down to ptr so the nearest one wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = IDW'((int'(ptr) + i) % N);
      if (req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx;
      end
    end
  end

  // Pointer moves to (granted + 1) mod N on every taken grant.
  always_ff @(posedge clk_i) begin
    if (!rst_ni)
      ptr <= '0;
    else if (advance)
      ptr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
  end

endmodule

// File: rtl/cache_line_refill_engine.sv
// Cache line refill engine: arbitrates line misses between caches and
// fetches the line from RAM one beat at a time, critical word first.
module cache_line_refill_engine
  import cache_pkg::*;
#(
  parameter  int N_REQ  = 2,
  parameter  int ADDR_W = 19,
  parameter  int RAM_W  = 32,
  parameter  int LINE_W = 128,
  localparam int IDW    = idw_f(N_REQ)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [N_REQ-1:0]        req_valid_i,
  input  logic [N_REQ*ADDR_W-1:0] req_addr_i,
  output logic [N_REQ-1:0]        req_done_o,
  output logic                    line_valid_o,
  output logic [LINE_W-1:0]       line_data_o,
  output logic [IDW-1:0]          line_id_o,
  output logic                    crit_valid_o,
  output logic [RAM_W-1:0]        crit_data_o,
  output logic                    ram_read_o,
  output logic [31:0]             ram_read_addr_o,
  input  logic                    ram_valid_i,
  input  logic [RAM_W-1:0]        ram_data_i,
  output logic                    busy_o
);

  localparam int BEATS  = beats_f(LINE_W, RAM_W);
  localparam int BOFF_W = boff_w_f(RAM_W);
  localparam int LOFF_W = loff_w_f(LINE_W);
  localparam int BI_W   = bidx_w_f(BEATS);
  localparam int CNT_W  = BI_W + 1;

  state_e             state;
  logic [ADDR_W-1:0]  line_base;
  logic [BI_W-1:0]    beat_idx;
  logic [CNT_W-1:0]   beat_cnt;
  logic [IDW-1:0]     gnt_id;

  logic               grant_valid;
  logic [IDW-1:0]     grant_idx;
  logic [ADDR_W-1:0]  sel_addr;
  logic [BI_W-1:0]    start_idx;

  cache_rr_arbiter #(.N(N_REQ)) u_arb (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req         (req_valid_i),
    .advance     (state == ST_IDLE && grant_valid),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // Winner's address and the word it actually missed on.
  always_comb begin
    sel_addr  = req_addr_i[grant_idx*ADDR_W +: ADDR_W];
    start_idx = sel_addr[BOFF_W +: BI_W] & BI_W'(BEATS - 1);
  end

  // Address is built only from latched state, so it cannot move mid-wait.
  assign ram_read_addr_o = 32'(line_base) | (32'(beat_idx) << BOFF_W);
  assign busy_o          = (state != ST_IDLE);

  // Main FSM; all pulses are registered and last exactly one cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state        <= ST_IDLE;
      line_base    <= '0;
      beat_idx     <= '0;
      beat_cnt     <= '0;
      gnt_id       <= '0;
      req_done_o   <= '0;
      line_valid_o <= 1'b0;
      line_data_o  <= '0;
      line_id_o    <= '0;
      crit_valid_o <= 1'b0;
      crit_data_o  <= '0;
      ram_read_o   <= 1'b0;
    end else begin
      req_done_o   <= '0;
      line_valid_o <= 1'b0;
      crit_valid_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            state      <= ST_FETCH;
            gnt_id     <= grant_idx;
            line_base  <= sel_addr & ~ADDR_W'((1 << LOFF_W) - 1);
            beat_idx   <= start_idx;
            beat_cnt   <= '0;
            ram_read_o <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (ram_valid_i) begin
            line_data_o[beat_idx*RAM_W +: RAM_W] <= ram_data_i;
            beat_idx <= (beat_idx + 1'b1) & BI_W'(BEATS - 1);
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt == '0) begin
              crit_data_o  <= ram_data_i;
              crit_valid_o <= 1'b1;
            end
            if (beat_cnt == CNT_W'(BEATS - 1)) begin
              state        <= ST_DONE;
              ram_read_o   <= 1'b0;
              line_valid_o <= 1'b1;
              line_id_o    <= gnt_id;
              req_done_o   <= N_REQ'(1) << gnt_id;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_line_refill_engine.sv
// Bench for the refill engine: directed scenarios plus randomized fills
// compared against a line-level reference model.
module tb_cache_line_refill_engine;

  localparam int N_REQ  = 2;
  localparam int ADDR_W = 19;
  localparam int RAM_W  = 32;
  localparam int LINE_W = 128;
  localparam int IDW    = 1;
  localparam int BEATS  = LINE_W / RAM_W;

  logic                    clk = 1'b0;
  logic                    rst_ni;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ-1:0]        req_done;
  logic                    line_valid;
  logic [LINE_W-1:0]       line_data;
  logic [IDW-1:0]          line_id;
  logic                    crit_valid;
  logic [RAM_W-1:0]        crit_data;
  logic                    ram_read;
  logic [31:0]             ram_read_addr;
  logic                    ram_valid;
  logic [RAM_W-1:0]        ram_data;
  logic                    busy;

  int checks = 0;
  int errors = 0;
  int rr     = 0;
  int lv;
  logic [LINE_W-1:0] last_line;
  logic [31:0]       addr_log[$];

  always #5 clk = ~clk;

  cache_line_refill_engine #(
    .N_REQ(N_REQ), .ADDR_W(ADDR_W), .RAM_W(RAM_W), .LINE_W(LINE_W)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_valid_i(req_valid), .req_addr_i(req_addr),
    .req_done_o(req_done), .line_valid_o(line_valid),
    .line_data_o(line_data), .line_id_o(line_id),
    .crit_valid_o(crit_valid), .crit_data_o(crit_data),
    .ram_read_o(ram_read), .ram_read_addr_o(ram_read_addr),
    .ram_valid_i(ram_valid), .ram_data_i(ram_data),
    .busy_o(busy)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".req_done"},   req_done,      0);
    chk({tag, ".line_valid"}, line_valid,    0);
    chk({tag, ".line_data"},  line_data,     0);
    chk({tag, ".line_id"},    line_id,       0);
    chk({tag, ".crit_valid"}, crit_valid,    0);
    chk({tag, ".crit_data"},  crit_data,     0);
    chk({tag, ".ram_read"},   ram_read,      0);
    chk({tag, ".ram_addr"},   ram_read_addr, 0);
    chk({tag, ".busy"},       busy,          0);
  endtask

  // Called at the negedge of the grant cycle; returns at the negedge of the
  // cycle that should carry line_valid, reporting its offset in lv_cycle.
  task automatic run_fill(input int gap, input bit data_is_addr, input bit keep_req,
                          input bit scramble, output int lv_cycle);
    int g, start, k, c, first_beat, next_beat, slot;
    logic [ADDR_W-1:0] a;
    logic [31:0]       base, ea, d, crit;
    logic [LINE_W-1:0] exp_line;
    g = -1;
    for (int i = 0; i < N_REQ; i++)
      if (g < 0 && 1'(req_valid >> ((rr + i) % N_REQ))) g = (rr + i) % N_REQ;
    chk("grant_exists", (g >= 0), 1);
    if (g < 0) g = 0;
    chk("idle_at_grant", busy, 0);
    a     = req_addr[g*ADDR_W +: ADDR_W];
    rr    = (g + 1) % N_REQ;
    start = int'(a / (RAM_W / 8)) % BEATS;
    base  = 32'(a) & ~32'(LINE_W / 8 - 1);
    exp_line = '0;
    crit  = '0;
    addr_log.delete();
    ram_valid  = 1'b0;
    first_beat = (gap < 1) ? 1 : gap;
    next_beat  = first_beat;
    k = 0;
    c = 0;
    while (k < BEATS) begin
      @(negedge clk);
      c++;
      slot = (start + k) % BEATS;
      ea   = base + 32'(slot * (RAM_W / 8));
      chk("fetch_busy",       busy,          1);
      chk("fetch_ram_read",   ram_read,      1);
      chk("fetch_addr",       ram_read_addr, ea);
      chk("fetch_line_valid", line_valid,    0);
      chk("fetch_req_done",   req_done,      0);
      chk("fetch_crit_valid", crit_valid,    (c == first_beat + 1));
      if (c == first_beat + 1) chk("crit_data", crit_data, crit);
      if (scramble) begin
        req_addr[g*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
        req_valid = req_valid ^ (N_REQ'($urandom_range(0, 1)) << g);
      end
      if (c == next_beat) begin
        d = data_is_addr ? ea : $urandom;
        addr_log.push_back(ram_read_addr);
        ram_valid = 1'b1;
        ram_data  = d;
        exp_line[slot*RAM_W +: RAM_W] = d;
        if (k == 0) crit = d;
        k++;
        next_beat = c + gap + 1;
      end else begin
        ram_valid = 1'b0;
        ram_data  = $urandom;
      end
    end
    @(negedge clk);
    c++;
    ram_valid = 1'($urandom);
    ram_data  = $urandom;
    chk("done_line_valid", line_valid, 1);
    chk("done_req_done",   req_done,   (N_REQ'(1) << g));
    chk("done_line_id",    line_id,    g);
    chk("done_line_data",  line_data,  exp_line);
    chk("done_crit_data",  crit_data,  crit);
    chk("done_ram_read",   ram_read,   0);
    chk("done_busy",       busy,       1);
    lv_cycle  = c;
    last_line = exp_line;
    if (!keep_req) req_valid = req_valid & ~(N_REQ'(1) << g);
  endtask

  // Reset asserted for one edge; returns at the negedge after release.
  task automatic do_reset();
    rst_ni = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    rr = 0;
  endtask

  initial begin
    rst_ni = 1'b0; req_valid = '0; req_addr = '0; ram_valid = 1'b0; ram_data = '0;
    repeat (2) @(negedge clk);
    chk_quiet("reset");
    rst_ni = 1'b1;

    // Stray RAM beats with nothing requested.
    for (int i = 0; i < 4; i++) begin
      ram_valid = 1'b1;
      ram_data  = $urandom;
      @(negedge clk);
      chk_quiet("idle_stray");
    end
    ram_valid = 1'b0;

    // Critical-word-first fill at 0x00104, RAM data = address.
    req_addr[0 +: ADDR_W] = 19'h00104;
    req_valid = 2'b01;
    run_fill(0, 1'b1, 1'b0, 1'b0, lv);
    chk("s1_latency", lv, 5);
    chk("s1_addr0", addr_log[0], 32'h104);
    chk("s1_addr1", addr_log[1], 32'h108);
    chk("s1_addr2", addr_log[2], 32'h10C);
    chk("s1_addr3", addr_log[3], 32'h100);
    chk("s1_line", line_data, 128'h0000010C_00000108_00000104_00000100);
    chk("s1_crit", crit_data, 32'h104);
    chk("s1_done", req_done, 2'b01);
    @(negedge clk);
    chk("s1_after_done", busy, 0);
    chk("s1_pulse_end",  line_valid, 0);

    // Both requesters continuously valid after reset: 0,1,0,1.
    do_reset();
    req_addr  = (N_REQ*ADDR_W)'({$urandom, $urandom});
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      run_fill(0, 1'b0, 1'b1, 1'b0, lv);
      chk("s2_grant_order", line_id, i % 2);
      chk("s2_onehot", $onehot(req_done), 1);
      @(negedge clk);
    end
    req_valid = '0;

    // Three idle cycles ahead of every beat.
    do_reset();
    req_addr[ADDR_W +: ADDR_W] = ADDR_W'($urandom);
    req_valid = 2'b10;
    run_fill(3, 1'b0, 1'b0, 1'b0, lv);
    chk("s3_latency", lv, 16);
    @(negedge clk);

    // Reset after two beats, then a stray beat.
    do_reset();
    req_addr[0 +: ADDR_W] = ADDR_W'($urandom);
    req_valid = 2'b01;
    @(negedge clk); ram_valid = 1'b1; ram_data = $urandom;
    @(negedge clk); ram_valid = 1'b1; ram_data = $urandom;
    @(negedge clk); chk("s4_busy_before", busy, 1);
    rst_ni = 1'b0; req_valid = '0; ram_valid = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1; rr = 0;
    chk_quiet("s4_after_reset");
    ram_valid = 1'b1; ram_data = $urandom;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_quiet("s4_stray");
      ram_valid = 1'($urandom);
      ram_data  = $urandom;
    end
    ram_valid = 1'b0;

    // Randomized fills with mid-fill request changes and idle stray beats.
    for (int it = 0; it < 40; it++) begin
      req_addr  = (N_REQ*ADDR_W)'({$urandom, $urandom});
      req_valid = N_REQ'($urandom_range(1, (1 << N_REQ) - 1));
      run_fill(int'($urandom_range(0, 2)), 1'b0, 1'b0, 1'b1, lv);
      @(negedge clk);
      req_valid = '0;
      ram_valid = 1'b1;
      ram_data  = $urandom;
      @(negedge clk);
      chk("rnd_idle_busy", busy, 0);
      chk("rnd_idle_hold", line_data, last_line);
      chk("rnd_idle_pulse", line_valid, 0);
      ram_valid = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cache_line_refill_engine.md
CACHE_LINE_REFILL_ENGINE -- requirements
Module: cache_line_refill_engine

Interface
REQ-001 SHALL have parameter N_REQ, default 2: number of requesting caches (index 0 = instruction, 1 = data).
REQ-002 SHALL have parameter ADDR_W, default 19: requester byte-address width.
REQ-003 SHALL have parameter RAM_W, default 32: RAM beat width in bits, power of two, at least 8.
REQ-004 SHALL have parameter LINE_W, default 128: cache line width in bits, an integer multiple of RAM_W; BEATS = LINE_W/RAM_W, a power of two.
REQ-005 SHALL have one clock `clk_i`; reset `rst_ni` is synchronous and active-low.
REQ-006 SHALL have ports, each listed as name, direction, width, meaning:
- `clk_i`  in  1  clock
- `rst_ni`  in  1  synchronous active-low reset
- `req_valid_i`  in  N_REQ  per-requester line-miss request, held until accepted
- `req_addr_i`  in  N_REQ*ADDR_W  packed miss byte addresses, requester k at [k*ADDR_W +: ADDR_W]
- `req_done_o`  out  N_REQ  one-hot, one-cycle completion pulse to the granted requester
- `line_valid_o`  out  1  one-cycle pulse, line_data_o/line_id_o valid
- `line_data_o`  out  LINE_W  assembled line, word w at [w*RAM_W +: RAM_W]
- `line_id_o`  out  IDW  granted requester index, IDW = max(1, clog2(N_REQ))
- `crit_valid_o`  out  1  one-cycle pulse, first (critical) beat available
- `crit_data_o`  out  RAM_W  critical beat data
- `ram_read_o`  out  1  RAM read request
- `ram_read_addr_o`  out  32  RAM beat byte address, zero-extended
- `ram_valid_i`  in  1  RAM returns a beat this cycle
- `ram_data_i`  in  RAM_W  RAM beat data
- `busy_o`  out  1  engine not in IDLE

Function
REQ-007 SHALL implement the states IDLE, FETCH and DONE.
REQ-008 In IDLE with any req_valid_i set, SHALL grant one requester round-robin, latch its address, and move to FETCH on the next edge.
REQ-009 After each grant, the round-robin pointer SHALL move to (granted+1) mod N_REQ; the pointer resets to 0.
REQ-010 Beat order SHALL be critical-word-first: starting word = address bits [clog2(LINE_W/8)-1 : clog2(RAM_W/8)], then increasing mod BEATS (wrap-around).
REQ-011 ram_read_addr_o SHALL equal {line base, current beat index, byte-offset zeros}.
REQ-012 In FETCH, ram_read_o SHALL be 1 and the address SHALL stay stable until ram_valid_i is seen.
REQ-013 At most one beat SHALL be outstanding at a time.
REQ-014 On each ram_valid_i in FETCH, the engine SHALL write the beat into its word slot of the line register and advance the beat index.
REQ-015 On the first beat, the engine SHALL also load crit_data_o and pulse crit_valid_o in the following cycle.
REQ-016 On the BEATS-th beat, the engine SHALL move to DONE.
REQ-017 DONE SHALL last one cycle, assert line_valid_o and req_done_o[grant], then return to IDLE.
REQ-018 A re-arbitration SHALL occur no earlier than the cycle after DONE.
REQ-019 ram_valid_i outside FETCH SHALL be ignored and SHALL leave all state unchanged.
REQ-020 Changes to the granted requester's req_valid_i or address during FETCH/DONE SHALL NOT affect the fill in progress.
REQ-021 Latency with ram_valid_i tied high: grant in IDLE cycle t, beats in cycles t+1 .. t+BEATS, line_valid_o in cycle t+BEATS+1.
REQ-022 line_data_o, line_id_o and crit_data_o SHALL hold their values until overwritten by the next fill.

Reset
REQ-023 While rst_ni=0 at a clock edge, the state SHALL become IDLE, and all outputs, line/critical registers, beat index and RR pointer SHALL become 0.
REQ-024 Reset in mid-FETCH SHALL abandon the fill with no line_valid_o or req_done_o pulse; a ram_valid_i arriving afterwards SHALL be ignored.

Structure
REQ-025 Shared package cache_pkg SHALL hold the state enum and the BEATS/IDW/offset-width helper localparams or functions.
REQ-026 Round-robin selection SHALL be a sub-module cache_rr_arbiter (N parameter; request, advance and grant index ports).

Verification (LINE_W=128, RAM_W=32, ADDR_W=19, N_REQ=2)
REQ-027 Scenario: req 0 at 0x00104, RAM data = address, ram_valid_i high.
- ram_read_addr_o sequence: 0x104, 0x108, 0x10C, 0x100.
- crit_data_o = 0x104.
- line_data_o = {0x10C, 0x108, 0x104, 0x100}.
- line_id_o = 0; req_done_o = 2'b01 at t+5.
REQ-028 Scenario: both requesters valid continuously after reset.
- Grants in order 0, 1, 0, 1.
- Each req_done_o pulse is one-hot.
REQ-029 Scenario: ram_valid_i delayed 3 cycles per beat.
- ram_read_o stays high with a stable address throughout each wait.
- line_valid_o arrives 16 cycles after the grant cycle.
REQ-030 Scenario: rst_ni low for one cycle after 2 beats, then a stray ram_valid_i.
- All outputs are 0 and busy_o = 0.
- No pulses occur and the state remains IDLE.
REQ-031 Scenario: ram_valid_i pulses while in IDLE with no requests.
- No state or output change.
